// File: rtl/banked_sector_memory.sv
// ---------------------------------------------------------------------------
// banked_sector_memory
//
// Multi-sector weight/activation store for the autoencoder datapath.
// NUM_SECTORS sectors of DEPTH words, each DATA_WIDTH bits wide. It has one
// write port, two independent registered read ports with write-first bypass,
// an optional read-only sector that always reads zero, and a clear engine
// that zeroes one sector at one word per cycle.
//
// Ports:
//   clock                    system clock, rising edge
//   reset_n                  synchronous active-low reset
//   en_write                 write request
//   sector_write_select      write sector
//   write_address            write word address
//   data_write               write data
//   wr_err                   one-cycle pulse: write or clear start rejected
//   rd_en_1 / rd_en_2        read requests
//   read_sector_selector_x   read sector per port
//   read_add_x               read word address per port
//   read_data_x              registered read data per port
//   rd_valid_x               read_data_x valid this cycle
//   clr_start                start clearing clr_sector
//   clr_sector               sector to clear, sampled when the start is accepted
//   clr_busy                 clear engine active
//   clr_done                 one-cycle pulse on the last clear write
// ---------------------------------------------------------------------------
module banked_sector_memory #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int SECTOR_WIDTH = 4,
  parameter int RO_SECTOR_EN = 1,
  parameter int RO_SECTOR    = (2**SECTOR_WIDTH) - 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    en_write,
  input  logic [SECTOR_WIDTH-1:0] sector_write_select,
  input  logic [ADDR_WIDTH-1:0]   write_address,
  input  logic [DATA_WIDTH-1:0]   data_write,
  output logic                    wr_err,
  input  logic                    rd_en_1,
  input  logic [SECTOR_WIDTH-1:0] read_sector_selector_1,
  input  logic [ADDR_WIDTH-1:0]   read_add_1,
  output logic [DATA_WIDTH-1:0]   read_data_1,
  output logic                    rd_valid_1,
  input  logic                    rd_en_2,
  input  logic [SECTOR_WIDTH-1:0] read_sector_selector_2,
  input  logic [ADDR_WIDTH-1:0]   read_add_2,
  output logic [DATA_WIDTH-1:0]   read_data_2,
  output logic                    rd_valid_2,
  input  logic                    clr_start,
  input  logic [SECTOR_WIDTH-1:0] clr_sector,
  output logic                    clr_busy,
  output logic                    clr_done
);

  localparam int DEPTH       = 2**ADDR_WIDTH;
  localparam int NUM_SECTORS = 2**SECTOR_WIDTH;
  localparam int WORDS       = NUM_SECTORS * DEPTH;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [SECTOR_WIDTH-1:0] RO_SEL    = SECTOR_WIDTH'(RO_SECTOR);
  localparam logic [ADDR_WIDTH-1:0]   LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic                    RO_ON     = (RO_SECTOR_EN != 0);

  // Storage is flattened; a word is addressed by {sector, address}.
  logic [DATA_WIDTH-1:0]   r_mem [WORDS];

  logic [0:0]              r_state;
  logic [SECTOR_WIDTH-1:0] r_clr_sector;
  logic [ADDR_WIDTH-1:0]   r_clr_count;
  logic                    r_wr_err;
  logic [DATA_WIDTH-1:0]   r_read_data [2];
  logic                    r_rd_valid  [2];

  logic                    w_busy;
  logic                    w_wr_accept;
  logic                    w_wr_reject;
  logic                    w_clr_accept;
  logic                    w_clr_reject;
  logic                    w_clr_last;
  logic [SECTOR_WIDTH+ADDR_WIDTH-1:0] w_wr_index;
  logic [SECTOR_WIDTH+ADDR_WIDTH-1:0] w_clr_index;

  logic                    w_rd_en     [2];
  logic [SECTOR_WIDTH-1:0] w_rd_sector [2];
  logic [ADDR_WIDTH-1:0]   w_rd_addr   [2];
  logic [DATA_WIDTH-1:0]   w_rd_next   [2];

  assign w_rd_en[0]     = rd_en_1;
  assign w_rd_en[1]     = rd_en_2;
  assign w_rd_sector[0] = read_sector_selector_1;
  assign w_rd_sector[1] = read_sector_selector_2;
  assign w_rd_addr[0]   = read_add_1;
  assign w_rd_addr[1]   = read_add_2;

  assign w_busy      = (r_state == ST_CLEAR);
  assign w_wr_index  = {sector_write_select, write_address};
  assign w_clr_index = {r_clr_sector, r_clr_count};

  // A write is refused when it hits the read-only sector or the sector the
  // clear engine currently owns; other sectors stay writable during a sweep.
  assign w_wr_accept = en_write
                     && !(RO_ON && (sector_write_select == RO_SEL))
                     && !(w_busy && (sector_write_select == r_clr_sector));
  assign w_wr_reject = en_write && !w_wr_accept;

  // clr_start is only looked at in IDLE; a start while sweeping is dropped
  // silently, a start on the read-only sector is reported as an error.
  assign w_clr_accept = !w_busy && clr_start && !(RO_ON && (clr_sector == RO_SEL));
  assign w_clr_reject = !w_busy && clr_start &&  (RO_ON && (clr_sector == RO_SEL));
  assign w_clr_last   = w_busy && (r_clr_count == LAST_ADDR);

  // Next read value per port. The read-only sector masks everything; after
  // that, a same-cycle accepted write or clear write to the same word wins
  // over the stored value. Write and clear can never target the same sector.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd_next[p] = r_mem[{w_rd_sector[p], w_rd_addr[p]}];
      if (RO_ON && (w_rd_sector[p] == RO_SEL)) begin
        w_rd_next[p] = '0;
      end else if (w_wr_accept && ({w_rd_sector[p], w_rd_addr[p]} == w_wr_index)) begin
        w_rd_next[p] = data_write;
      end else if (w_busy && ({w_rd_sector[p], w_rd_addr[p]} == w_clr_index)) begin
        w_rd_next[p] = '0;
      end
    end
  end

  // Storage: user writes and the clear engine's zero writes share the array.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr_accept) begin
        r_mem[w_wr_index] <= data_write;
      end
      if (w_busy) begin
        r_mem[w_clr_index] <= '0;
      end
    end
  end

  // Read ports: data only updates on a request so it holds otherwise.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int p = 0; p < 2; p++) begin
        r_read_data[p] <= '0;
        r_rd_valid[p]  <= 1'b0;
      end
      r_wr_err <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        r_rd_valid[p] <= w_rd_en[p];
        if (w_rd_en[p]) begin
          r_read_data[p] <= w_rd_next[p];
        end
      end
      r_wr_err <= w_wr_reject || w_clr_reject;
    end
  end

  // Clear engine: one zero write per cycle in CLEAR; the counter wraps back
  // to 0 on the final word so it is ready for the next sweep.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_clr_sector <= '0;
      r_clr_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_clr_accept) begin
            r_state      <= ST_CLEAR;
            r_clr_sector <= clr_sector;
            r_clr_count  <= '0;
          end
        end
        ST_CLEAR: begin
          r_clr_count <= r_clr_count + 1'b1;
          if (w_clr_last) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign read_data_1 = r_read_data[0];
  assign read_data_2 = r_read_data[1];
  assign rd_valid_1  = r_rd_valid[0];
  assign rd_valid_2  = r_rd_valid[1];
  assign wr_err      = r_wr_err;
  assign clr_busy    = w_busy;
  // Gated with reset_n so a sweep aborted on its last word never signals done.
  assign clr_done    = w_clr_last && reset_n;

endmodule

// File: doc/banked_sector_memory.md
Name: banked_sector_memory

Overview:
- Parametrised multi-sector weight/activation store for the autoencoder datapath. Successor to the fixed 16-sector × 16-word × 16-bit two-read-port memory.
- Adds the following over that memory:
  - configurable data width, word depth and sector count;
  - registered reads with valid strobes and write-first bypass;
  - a protected read-only sector with error reporting;
  - a sequential per-sector clear engine, so a layer's buffer can be zeroed between inference passes without the controller issuing DEPTH writes.

Parameters:
- DATA_WIDTH, 16, bits per word.
- ADDR_WIDTH, 4, word address width; DEPTH = 2**ADDR_WIDTH words per sector.
- SECTOR_WIDTH, 4, sector select width; NUM_SECTORS = 2**SECTOR_WIDTH.
- RO_SECTOR_EN, 1, 1 = sector RO_SECTOR is read-only.
- RO_SECTOR, NUM_SECTORS-1, index of the read-only sector; it always reads 0.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- en_write  in  1  write request.
- sector_write_select  in  SECTOR_WIDTH  write sector.
- write_address  in  ADDR_WIDTH  write word address.
- data_write  in  DATA_WIDTH  write data.
- wr_err  out  1  one-cycle pulse: a write or clear was rejected.
- rd_en_1  in  1  read request, port 1.
- read_sector_selector_1  in  SECTOR_WIDTH  read sector, port 1.
- read_add_1  in  ADDR_WIDTH  read word address, port 1.
- read_data_1  out  DATA_WIDTH  registered read data, port 1.
- rd_valid_1  out  1  read_data_1 valid this cycle.
- rd_en_2, read_sector_selector_2, read_add_2, read_data_2, rd_valid_2: identical to port 1, for port 2.
- clr_start  in  1  start clearing sector clr_sector.
- clr_sector  in  SECTOR_WIDTH  sector to clear; sampled when clr_start is accepted.
- clr_busy  out  1  clear engine active.
- clr_done  out  1  one-cycle pulse when the clear completes.

Behaviour:

Reset:
- reset_n=0 at a clock edge zeroes all storage words, read_data_1/2, rd_valid_1/2, wr_err, clr_busy and clr_done; FSM goes to IDLE.
- Reset mid-clear aborts the sweep: no clr_done, clr_busy=0 the next cycle.

Write:
- en_write=1 commits data_write to [sector_write_select][write_address] at the edge; zero added latency.
- Rejected writes: storage unchanged, wr_err=1 the next cycle. A write is rejected when:
  - RO_SECTOR_EN=1 and sector_write_select==RO_SECTOR; or
  - clr_busy=1 and sector_write_select equals the latched clear sector.
- Writes to all other sectors proceed while a clear runs.

Read:
- Each port is independent with latency 1: request at cycle N gives read_data_x and rd_valid_x=1 at cycle N+1.
- rd_en_x=0: rd_valid_x=0 next cycle; read_data_x holds its previous value.
- Read-only sector always returns 0.
- Write-first bypass: if an accepted write in cycle N targets the same sector and address as a read in cycle N, that read returns data_write.
- A rejected write is never bypassed.
- Both ports may read the same location in the same cycle.

Clear FSM (states IDLE, CLEAR):
- IDLE, clr_start=1:
  - if clr_sector is the read-only sector (RO_SECTOR_EN=1): ignored, wr_err pulse;
  - otherwise: latch the sector, clear counter=0, go to CLEAR; clr_busy=1 from the next cycle.
- CLEAR: each cycle write 0 to [latched][counter] and increment the counter.
  - When counter==DEPTH-1, that zero is written, clr_done pulses in the same cycle, and the FSM goes to IDLE; clr_busy=0 the following cycle.
  - Total busy duration: DEPTH cycles.
- clr_start while in CLEAR: ignored, no error.
- Reads of the clearing sector during a sweep return 0 for already-swept addresses and old data otherwise. The bypass rule also applies to clear writes.
- The counter is ADDR_WIDTH bits and wraps 0 at completion.
- Width rules: no arithmetic on data; sector and address indices are unsigned and always in range.

Test Plan:
- Write 16'hA5A5 to sector 3 addr 7, then read port 1 (3,7) and port 2 (3,7) the next cycle -> both return 16'hA5A5 one cycle after the request, with rd_valid_1=rd_valid_2=1.
- Same cycle: write 16'h1234 to (2,4) and read port 2 (2,4); old value was 16'h0F0F -> read_data_2=16'h1234 next cycle (bypass).
- Write 16'hFFFF to sector 15 (RO) addr 0 -> wr_err=1 next cycle; a read of (15,0) returns 0.
- Fill sector 5 with 16'h0001..16'h0010, then clr_start on sector 5:
  - clr_busy is high for 16 cycles and clr_done pulses once;
  - a write to (5,2) mid-sweep gives wr_err;
  - a write to (6,2) succeeds;
  - all of sector 5 reads 0 afterwards.
- Start a clear of sector 1, assert reset_n=0 at sweep cycle 8 -> clr_busy=0, no clr_done, and every location reads 0 after reset.
- Assert clr_start for sector 9 while the sector 1 clear is still busy -> ignored; sector 9 data is unchanged and wr_err stays 0.
